// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//   - state_t        : control FSM states (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH  : operand width used when the top is not overridden
//   - CNT_W          : bit counter width for DEFAULT_WIDTH
//   - CARRY_SEED     : carry-in for the LSB (the "+1" of two's-complement negation)
//   - cnt_width()    : counter width for an arbitrary operand width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
  // It is clamped to one bit so a degenerate width still yields a legal vector.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

  // A - B = A + ~B + 1, so the carry into the LSB starts at one.
  localparam logic CARRY_SEED = 1'b1;

endpackage

// File: rtl/serial_subtractor_sub_bit_cell.sv
// sub_bit_cell
//   Combinational 1-bit subtract cell: a full adder whose B input is inverted
//   internally, so a chain of these seeded with carry=1 computes A - B.
//   Ports:
//     i_A     - minuend bit
//     i_B     - subtrahend bit (inverted inside the cell)
//     i_C     - carry in (1 means "no borrow")
//     o_diff  - difference bit
//     o_carry - carry out (0 means a borrow propagates)
module sub_bit_cell (
  input  logic i_A,
  input  logic i_B,
  input  logic i_C,
  output logic o_diff,
  output logic o_carry
);

  logic b_inv;
  logic half_sum;

  // Plain full adder on (A, ~B, C).
  always_comb begin
    b_inv    = ~i_B;
    half_sum = i_A ^ b_inv;
    o_diff   = half_sum ^ i_C;
    o_carry  = (i_A & b_inv) | (i_C & half_sum);
  end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor, one bit per clock, LSB first.
//   A start/busy/done handshake lets a controller issue operations; a start
//   during the DONE cycle chains the next operation with no idle bubble.
//   Ports:
//     i_clk    - rising-edge clock
//     i_reset  - asynchronous active-high reset
//     i_start  - request pulse, honoured only in IDLE or DONE
//     i_A/i_B  - operands, captured on the accepting edge
//     o_diff   - A - B modulo 2^WIDTH, held until the next result
//     o_borrow - set when A < B (unsigned)
//     o_zero   - set when o_diff is zero
//     o_busy   - high while bits are being processed
//     o_done   - one-cycle pulse when a new result is presented
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_zero,
  output logic             o_busy,
  output logic             o_done
);

  localparam int                CNT_BITS = cnt_width(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

  state_t               state_q;
  state_t               state_d;
  logic                 load;
  logic                 step;
  logic                 finish;

  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [WIDTH-1:0]     res_sh;
  logic [WIDTH-1:0]     res_next;
  logic                 carry;
  logic [CNT_BITS-1:0]  cnt;

  logic                 bit_diff;
  logic                 bit_carry;

  sub_bit_cell u_cell (
    .i_A     (a_sh[0]),
    .i_B     (b_sh[0]),
    .i_C     (carry),
    .o_diff  (bit_diff),
    .o_carry (bit_carry)
  );

  // The new bit enters at the MSB, so after WIDTH steps the LSB-first stream
  // lines up in natural order. The final edge uses this value directly so the
  // last bit does not need an extra cycle to land in res_sh.
  always_comb begin
    res_next = {bit_diff, res_sh[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes. A start in RUN is deliberately not
  // looked at, so a stray pulse cannot disturb the operation in flight.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift registers, bit counter and the registered result outputs. The
  // counter is returned to zero on the final step rather than incremented,
  // so it never wraps even when WIDTH is a power of two.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
      o_zero   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= finish;
      if (load) begin
        a_sh   <= i_A;
        b_sh   <= i_B;
        res_sh <= '0;
        carry  <= CARRY_SEED;
        cnt    <= '0;
        o_busy <= 1'b1;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= res_next;
        carry  <= bit_carry;
        if (finish) begin
          cnt      <= '0;
          o_diff   <= res_next;
          o_borrow <= ~bit_carry;
          o_zero   <= (res_next == '0);
          o_busy   <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and randomized checks of serial_subtractor at WIDTH = 8.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         i_clk;
  logic         i_reset;
  logic         i_start;
  logic [W-1:0] i_A;
  logic [W-1:0] i_B;
  logic [W-1:0] o_diff;
  logic         o_borrow;
  logic         o_zero;
  logic         o_busy;
  logic         o_done;

  int vecCount = 0;
  int errCount = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_A      (i_A),
    .i_B      (i_B),
    .o_diff   (o_diff),
    .o_borrow (o_borrow),
    .o_zero   (o_zero),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  // 10-unit clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Single comparison point: counts every check and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a start pulse for one cycle; returns on the falling edge right
  // after the accepting rising edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    i_A     = a;
    i_B     = b;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_A     = '0;
    i_B     = '0;
  endtask

  // Steps falling edges until o_done, reporting cycles waited and how many
  // of those sampled edges (including the current one) saw o_busy high.
  task automatic waitDone(input string tag, output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = o_busy ? 1 : 0;
    while (!o_done && cycles < 40) begin
      @(negedge i_clk);
      cycles++;
      if (o_busy) busyCycles++;
    end
    if (!o_done) checkOutput({tag, "_timeout"}, 32'(o_done), 32'd1);
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] d, input logic br, input logic z);
    checkOutput({tag, "_diff"},   32'(o_diff),   32'(d));
    checkOutput({tag, "_borrow"}, 32'(o_borrow), 32'(br));
    checkOutput({tag, "_zero"},   32'(o_zero),   32'(z));
  endtask

  // Directed vector: start, wait, check result and latency, check done drops.
  task automatic runVector(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] d, input logic br, input logic z);
    int cyc;
    int busy;
    applyStimulus(a, b);
    waitDone(tag, cyc, busy);
    checkResult(tag, d, br, z);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'd8);
    checkOutput({tag, "_busy_len"}, 32'(busy), 32'd8);
    @(negedge i_clk);
    checkOutput({tag, "_done_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int cyc;
    int busy;
    int pulses;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rd;

    i_reset = 1'b1;
    i_start = 1'b0;
    i_A     = '0;
    i_B     = '0;
    repeat (2) @(negedge i_clk);
    checkOutput("reset_diff", 32'(o_diff), 32'd0);
    checkOutput("reset_flags", {27'd0, o_borrow, o_zero, o_busy, o_done, 1'b0}, 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    runVector("sub_100_37", 8'd100, 8'd37, 8'd63,   1'b0, 1'b0);
    runVector("sub_37_100", 8'd37,  8'd100, 8'hC1,  1'b1, 1'b0);
    runVector("sub_equal",  8'h5A,  8'h5A,  8'h00,  1'b0, 1'b1);
    runVector("sub_0_1",    8'h00,  8'h01,  8'hFF,  1'b1, 1'b0);

    // Mid-RUN start is ignored; a start in the DONE cycle chains directly.
    applyStimulus(8'hFF, 8'h01);
    repeat (2) @(negedge i_clk);
    applyStimulus(8'h00, 8'h00);
    waitDone("ignore_start", cyc, busy);
    checkResult("ignore_start", 8'hFE, 1'b0, 1'b0);
    applyStimulus(8'd9, 8'd4);
    checkOutput("b2b_busy_now", 32'(o_busy), 32'd1);
    checkOutput("b2b_done_drop", 32'(o_done), 32'd0);
    waitDone("b2b", cyc, busy);
    checkResult("b2b", 8'd5, 1'b0, 1'b0);
    checkOutput("b2b_latency", 32'(cyc), 32'd8);
    @(negedge i_clk);

    // Asynchronous abort during the fourth RUN cycle.
    applyStimulus(8'h33, 8'h11);
    repeat (3) @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    checkOutput("abort_diff", 32'(o_diff), 32'd0);
    checkOutput("abort_flags", {27'd0, o_borrow, o_zero, o_busy, o_done, 1'b0}, 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      if (o_done) pulses++;
    end
    checkOutput("abort_no_done", 32'(pulses), 32'd0);
    runVector("after_abort", 8'h33, 8'h11, 8'h22, 1'b0, 1'b0);

    // Randomized operands against (A - B) mod 256 and A < B.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rd = ra - rb;
      applyStimulus(ra, rb);
      waitDone("rand", cyc, busy);
      checkResult("rand", rd, (ra < rb), (rd == '0));
      @(negedge i_clk);
      checkOutput("rand_done_pulse", 32'(o_done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor for the calculator datapath; computes A - B one bit per clock, LSB first.
- Inverse operation of the ripple adder: each bit uses a 1-bit full-adder cell fed with inverted B, and the carry-in is seeded to 1.
- Sits beside the adder in the arithmetic unit. A start/busy/done handshake lets the control FSM issue operations and collect results.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  request pulse. Sampled only in IDLE or DONE.
- i_A  input  WIDTH  minuend, captured on the accepting edge.
- i_B  input  WIDTH  subtrahend, captured on the accepting edge.
- o_diff  output  WIDTH  result A - B modulo 2^WIDTH.
- o_borrow  output  1  high when A < B (unsigned).
- o_zero  output  1  high when o_diff == 0.
- o_busy  output  1  high while bits are being processed.
- o_done  output  1  single-cycle pulse marking the result as valid.

Interface: one clock; reset is asynchronous and active-high (clock port i_clk, reset port i_reset).

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - o_diff = 0, o_borrow = 0, o_zero = 0, o_busy = 0, o_done = 0.
  - Internal shift registers, carry and counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - If i_start = 1 at the edge: load a_sh <= i_A, b_sh <= i_B, carry <= 1, cnt <= 0; go to RUN; o_busy <= 1.
  - Otherwise remain in IDLE.
- RUN, one bit per edge:
  - s = a_sh[0] ^ ~b_sh[0] ^ carry.
  - carry <= (a_sh[0] & ~b_sh[0]) | (carry & (a_sh[0] ^ ~b_sh[0])).
  - a_sh and b_sh shift right by one.
  - The result shift register shifts right with s inserted at the MSB.
  - cnt increments each edge.
- Leaving RUN, on the edge where cnt == WIDTH-1:
  - Go to DONE.
  - o_diff <= final result register; o_borrow <= ~(final carry out); o_zero <= (final result == 0).
  - o_busy <= 0; o_done <= 1.
- DONE lasts one cycle. o_done <= 0 on the next edge.
  - If i_start = 1 in DONE: new operands are loaded and state goes to RUN (back-to-back operation, no idle bubble).
  - Otherwise go to IDLE.
- Latency: the result is valid, with o_done high, in the cycle after the (WIDTH+1)-th rising edge counted from the accepting edge. Throughput is one operation per WIDTH+1 cycles.
- o_diff, o_borrow and o_zero hold their value until the next DONE. They do not change during RUN.
- i_start while in RUN is ignored. The operation in flight is unaffected.
- i_A and i_B are don't-care after the accepting edge.
- Reset asserted mid-RUN aborts the operation: all outputs return to their reset values, and no o_done is produced.
- Wrap-around: the result is modulo 2^WIDTH. For example, 0 - 1 gives all ones with o_borrow = 1.
- The counter width is clog2(WIDTH). The counter must not overflow for WIDTH equal to a power of 2.

Decomposition:
- Shared package:
  - state enum (IDLE, RUN, DONE).
  - localparam for the counter width, clog2(WIDTH).
  - carry-in seed constant (1'b1).
- One natural sub-module: sub_bit_cell. This is a combinational 1-bit cell with:
  - inputs i_A, i_B, i_C;
  - outputs o_diff, o_carry;
  - internal B inversion.
- The top module holds the FSM, the shift registers, the counter and the output registers.

Test Plan:
- WIDTH=8, A=100, B=37, start pulse: o_done is high WIDTH+1 edges later with o_diff=63, o_borrow=0, o_zero=0. o_busy is high for exactly 8 cycles.
- A=37, B=100: o_diff=0xC1 (193), o_borrow=1, o_zero=0.
- A=0x5A, B=0x5A: o_diff=0, o_zero=1, o_borrow=0. A second case A=0x00, B=0x01: o_diff=0xFF, o_borrow=1.
- Start A=0xFF, B=0x01. Pulse i_start again mid-RUN with A=0, B=0: the second pulse is ignored and the result is o_diff=0xFE. In the DONE cycle apply start with A=9, B=4: the next result is 5, with no IDLE cycle in between.
- Assert i_reset asynchronously (between clock edges) during cycle 4 of RUN: all outputs are 0 immediately, and no o_done pulse appears. A new start after release gives a correct result.
- Random regression of 1000 operand pairs against a reference model of (A - B) mod 256 and A < B, checking that o_done is exactly one cycle wide.
